// File: rtl/phantom_clock.sv
// phantom_clock: phantom real-time clock hidden behind a card ROM window.
// A 64-bit key written serially through A0 unlocks one 64-access transfer
// that either reads a snapshot of the running BCD time or writes a new one.
module phantom_clock #(
    parameter int unsigned TICKDIV = 71590,
    parameter logic [63:0] PATTERN = 64'hC53A_A35C_C53A_A35C
) (
    input  logic C7M,
    input  logic nRES,
    input  logic nCEI,
    input  logic A2,
    input  logic A0,
    output logic RAMROMCSgb,
    output logic Q,
    output logic QOE
);
    localparam int            PW       = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICKDIV - 1);
    // year 00, month 01, date 01, day 1, 00:00:00.00
    localparam logic [63:0]   TIME_RST = 64'h0001_0101_0000_0000;

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t        state_q;
    logic [5:0]    idx_q;
    logic [63:0]   sh_q, sh_d;
    logic [63:0]   time_q, time_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          dirty_q, dirty_d;
    logic          blk_q, q_q;
    logic          ncei_s1_q, ncei_s2_q, ncei_s3_q;
    logic          ev, ev_xfer, last, commit, tick;
    logic [8:0]    hs_c, ss_c, ms_c, hh_c, dd_c;

    // BCD increment of one field; returns {carry, next}. Out-of-range or
    // non-BCD contents roll over to the minimum exactly like a normal wrap.
    function automatic logic [8:0] bcd_step(input logic [7:0] v,
                                            input logic [7:0] vmax,
                                            input logic [7:0] vmin);
        logic [8:0] r;
        if (v[3:0] > 4'd9 || v >= vmax) r = {1'b1, vmin};
        else if (v[3:0] == 4'd9)        r = {1'b0, v[7:4] + 4'd1, 4'd0};
        else                            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    assign RAMROMCSgb = !nCEI && !blk_q;
    assign QOE        = !nCEI && blk_q && A2;
    assign Q          = q_q;

    // Synchronise chip enable; the third flop only serves edge detection
    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            ncei_s1_q <= 1'b1;
            ncei_s2_q <= 1'b1;
            ncei_s3_q <= 1'b1;
        end else begin
            ncei_s1_q <= nCEI;
            ncei_s2_q <= ncei_s1_q;
            ncei_s3_q <= ncei_s2_q;
        end
    end

    assign ev      = ncei_s3_q && !ncei_s2_q;
    assign ev_xfer = ev && (state_q == XFER);
    assign last    = (idx_q == 6'd63);

    // Transfer shift: reads shift out bit 0, writes push A0 in at bit 63
    always_comb begin
        sh_d    = sh_q;
        dirty_d = dirty_q;
        if (ev_xfer) begin
            if (A2) begin
                sh_d = {1'b0, sh_q[63:1]};
            end else begin
                sh_d    = {A0, sh_q[63:1]};
                dirty_d = 1'b1;
            end
        end
    end

    assign commit = ev_xfer && last && dirty_d;

    // Access-driven FSM: key recognition, transfer, block flag, read bit
    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sh_q    <= '0;
            dirty_q <= 1'b0;
            blk_q   <= 1'b0;
            q_q     <= 1'b0;
        end else begin
            // Between accesses only, so BLK and Q are constant within one
            if (ncei_s2_q) begin
                blk_q <= (state_q == XFER);
                q_q   <= sh_q[0];
            end
            if (ev) begin
                case (state_q)
                    IDLE: begin
                        if (!A2 && (A0 == PATTERN[idx_q])) begin
                            if (last) begin
                                state_q <= XFER;
                                idx_q   <= '0;
                                sh_q    <= time_q;
                                dirty_q <= 1'b0;
                            end else begin
                                idx_q <= idx_q + 6'd1;
                            end
                        end else begin
                            idx_q <= '0;
                        end
                    end
                    XFER: begin
                        sh_q    <= sh_d;
                        dirty_q <= dirty_d;
                        if (last) begin
                            state_q <= IDLE;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 6'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Prescaler and BCD carry chain; a commit overrides a same-cycle tick
    always_comb begin
        tick   = (pre_q == PRE_MAX);
        hs_c   = bcd_step(time_q[7:0],   8'h99, 8'h00);
        ss_c   = bcd_step(time_q[15:8],  8'h59, 8'h00);
        ms_c   = bcd_step(time_q[23:16], 8'h59, 8'h00);
        hh_c   = bcd_step(time_q[31:24], 8'h23, 8'h00);
        dd_c   = bcd_step(time_q[39:32], 8'h07, 8'h01);
        time_d = time_q;
        pre_d  = tick ? '0 : pre_q + PW'(1);
        if (tick) begin
            time_d[7:0] = hs_c[7:0];
            if (hs_c[8]) begin
                time_d[15:8] = ss_c[7:0];
                if (ss_c[8]) begin
                    time_d[23:16] = ms_c[7:0];
                    if (ms_c[8]) begin
                        time_d[31:24] = hh_c[7:0];
                        if (hh_c[8]) time_d[39:32] = dd_c[7:0];
                    end
                end
            end
        end
        if (commit) begin
            time_d = sh_d;
            pre_d  = '0;
        end
    end

    // Live time and prescaler registers
    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            time_q <= TIME_RST;
            pre_q  <= '0;
        end else begin
            time_q <= time_d;
            pre_q  <= pre_d;
        end
    end
endmodule

// File: doc/phantom_clock.md
PHANTOM_CLOCK -- requirements
Module: phantom_clock

Interface
REQ-001 Parameter TICKDIV, default 71590: C7M cycles per 1/100 s tick.
REQ-002 Parameter PATTERN, default 64'hC53A_A35C_C53A_A35C: recognition key, bit 0 entered first.
REQ-003 C7M  input  1  sole clock; all flops on posedge C7M.
REQ-004 nRES  input  1  reset, asynchronous, active-low.
REQ-005 nCEI  input  1  card ROM/RAM chip enable (nRAMROMCS), active-low, asynchronous to C7M.
REQ-006 A2  input  1  access type; 0 = clock write, 1 = clock read.
REQ-007 A0  input  1  serial write data bit.
REQ-008 RAMROMCSgb  output  1  gated, inverted chip enable to card ROM/SRAM logic.
REQ-009 Q  output  1  serial read data bit.
REQ-010 QOE  output  1  drive enable for Q onto Apple II D0.

Function
REQ-011 nCEI SHALL pass through a 2-flop synchronizer; an access event is a synchronized high-to-low transition, with A2/A0 sampled in the same cycle.
REQ-012 FSM states SHALL be IDLE (recognising) and XFER; a 6-bit index counts accesses in both.
REQ-013 IDLE, write event, A0 == PATTERN[index]: index +1; mismatch: index <- 0.
REQ-014 IDLE, read event: index <- 0.
REQ-015 IDLE, matching write at index 63: state <- XFER, index <- 0, 64-bit shift register <- snapshot of live time, dirty <- 0.
REQ-016 XFER, read event: Q presents shift bit 0 for that access, then register shifts right one.
REQ-017 XFER, write event: A0 enters bit 63 as register shifts right, dirty <- 1.
REQ-018 XFER, 64th event: state <- IDLE, index <- 0; if dirty, live time <- shift register and prescaler <- 0.
REQ-019 A flag BLK SHALL update only while synchronized nCEI is high: BLK <- (state == XFER).
REQ-020 RAMROMCSgb SHALL equal !nCEI && !BLK; the 64th pattern access passes through, all 64 XFER accesses are blocked.
REQ-021 QOE SHALL equal !nCEI && BLK && A2; Q SHALL be held stable for the whole read access.
REQ-022 Time layout, LSB first, all BCD: byte0 hundredths 00-99, byte1 seconds 00-59, byte2 minutes 00-59, byte3 hours 00-23, byte4 day 1-7, byte5 date 01-31, byte6 month 01-12, byte7 year 00-99.
REQ-023 Prescaler SHALL count 0..TICKDIV-1 and wrap; the wrap cycle is a tick.
REQ-024 Tick SHALL increment hundredths.
REQ-025 Carries: 99->00 advances seconds; 59->00 advances minutes; 59->00 advances hours; 23->00 advances day; day 7->1.
REQ-026 Date, month and year SHALL never auto-advance; software maintains them.
REQ-027 Ticks SHALL continue during XFER; only the snapshot is frozen.
REQ-028 A commit coinciding with a tick SHALL win; that tick is discarded.
REQ-029 Written non-BCD or out-of-range values SHALL be stored as written; the next carry of that field wraps to its minimum.

Reset
REQ-030 nRES low SHALL immediately force state IDLE, index 0, BLK 0, dirty 0, shift register 0, prescaler 0.
REQ-031 nRES low SHALL reset time to 00:00:00.00, day 1, date 01, month 01, year 00.
REQ-032 Outputs during reset SHALL be RAMROMCSgb = !nCEI, QOE = 0, Q = 0.
REQ-033 Reset mid-XFER SHALL discard the transfer with no commit.

Verification
REQ-034 Unlock/read: 64 PATTERN writes, then 64 reads -> RAMROMCSgb high on all 64 pattern accesses and low on all reads; Q serialises the snapshot LSB first; next access passes through.
REQ-035 Mismatch: 30 correct bits, 1 wrong bit, then full pattern -> XFER only after 64 further correct writes.
REQ-036 Read abort: 40 correct bits, 1 read, then 24 correct bits -> stays IDLE with index 24.
REQ-037 Set/readback: unlock, write 23:59:59.99 day 7, unlock, read -> time returned; TICKDIV=4, 1 tick -> 00:00:00.00 day 1.
REQ-038 Commit race: commit on a tick cycle -> written value exact, prescaler 0.
REQ-039 Reset mid-XFER at bit 20 -> IDLE; time unchanged from reset value; next access passes through.
